pipelined_memory: RTL and testbench



---
 rtl/pipelined_memory.sv | 162 ++++++++++++++++
 tb/tb_pipelined_memory.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_memory.sv
// rtl/pipelined_memory.sv - dual-port (instruction/data) byte-addressed memory with fixed-latency response pipelines
// Optional zero-fill after reset; each port's pipeline freezes while its response is back-pressured.

module pipelined_memory_resp_pipe #(
  parameter int LAT = 1,
  parameter int DW  = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic [DW-1:0] i_data,
  input  logic          i_err,
  input  logic          i_ready,
  output logic          o_valid,
  output logic [DW-1:0] o_data,
  output logic          o_err
);
  logic [LAT-1:0] r_v;
  logic [LAT-1:0] r_err;
  logic [DW-1:0]  r_data [LAT];
  logic           w_stall;

  assign w_stall = r_v[LAT-1] && !i_ready;
  assign o_valid = r_v[LAT-1];
  assign o_data  = r_data[LAT-1];
  assign o_err   = r_err[LAT-1];

  // Bubbles are carried rather than collapsed so latency stays fixed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v   <= '0;
      r_err <= '0;
      for (int k = 0; k < LAT; k++) r_data[k] <= '0;
    end else if (!w_stall) begin
      r_v[0]    <= i_push;
      r_err[0]  <= i_push && i_err;
      r_data[0] <= i_push ? i_data : '0;
      for (int k = 1; k < LAT; k++) begin
        r_v[k]    <= r_v[k-1];
        r_err[k]  <= r_err[k-1];
        r_data[k] <= r_data[k-1];
      end
    end
  end
endmodule

module pipelined_memory #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_SIZE       = 262144,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_req_valid,
  output logic                    i_req_ready,
  input  logic [ADDR_WIDTH-1:0]   i_req_addr,
  output logic                    i_resp_valid,
  input  logic                    i_resp_ready,
  output logic [DATA_WIDTH-1:0]   i_resp_data,
  output logic                    i_resp_err,
  input  logic                    d_req_valid,
  output logic                    d_req_ready,
  input  logic [ADDR_WIDTH-1:0]   d_req_addr,
  input  logic                    d_req_we,
  input  logic [DATA_WIDTH-1:0]   d_req_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_req_be,
  output logic                    d_resp_valid,
  input  logic                    d_resp_ready,
  output logic [DATA_WIDTH-1:0]   d_resp_data,
  output logic                    d_resp_err,
  output logic                    busy
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int WORDS = MEM_SIZE / BYTES;
  localparam int IDXW  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int OFFW  = $clog2(BYTES);
  localparam logic [ADDR_WIDTH:0] LAST_OK = (ADDR_WIDTH+1)'(MEM_SIZE - BYTES);

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [IDXW-1:0]       r_clr_idx;
  logic [DATA_WIDTH-1:0] r_mem [WORDS];

  logic                  w_clearing;
  logic                  w_i_acc, w_i_err;
  logic                  w_d_acc, w_d_err, w_d_wr;
  logic [IDXW-1:0]       w_i_idx, w_d_idx;
  logic [DATA_WIDTH-1:0] w_i_rdata, w_d_rdata;

  function automatic logic addr_bad(input logic [ADDR_WIDTH-1:0] a);
    return ((a & ADDR_WIDTH'(BYTES - 1)) != '0) || ({1'b0, a} > LAST_OK);
  endfunction

  assign w_clearing  = (r_state == S_CLEAR);
  assign busy        = rst ? (CLEAR_ON_RESET != 0) : w_clearing;
  assign i_req_ready = !rst && !w_clearing && !(i_resp_valid && !i_resp_ready);
  assign d_req_ready = !rst && !w_clearing && !(d_resp_valid && !d_resp_ready);

  assign w_i_acc   = i_req_valid && i_req_ready;
  assign w_i_err   = addr_bad(i_req_addr);
  assign w_i_idx   = IDXW'(i_req_addr >> OFFW);
  assign w_i_rdata = w_i_err ? '0 : r_mem[w_i_idx];

  assign w_d_acc   = d_req_valid && d_req_ready;
  assign w_d_err   = addr_bad(d_req_addr);
  assign w_d_idx   = IDXW'(d_req_addr >> OFFW);
  assign w_d_rdata = (w_d_err || d_req_we) ? '0 : r_mem[w_d_idx];
  assign w_d_wr    = w_d_acc && d_req_we && !w_d_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;
      r_clr_idx <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_clearing) r_clr_idx <= r_clr_idx + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == S_CLEAR && r_clr_idx == IDXW'(WORDS - 1)) w_state_nxt = S_RUN;
  end

  // Reads above see pre-edge contents, so a same-cycle write never leaks into a read.
  always_ff @(posedge clk) begin
    if (!rst && w_clearing) begin
      r_mem[r_clr_idx] <= '0;
    end else if (w_d_wr) begin
      for (int k = 0; k < BYTES; k++)
        if (d_req_be[k]) r_mem[w_d_idx][8*k +: 8] <= d_req_wdata[8*k +: 8];
    end
  end

  pipelined_memory_resp_pipe #(.LAT(READ_LATENCY), .DW(DATA_WIDTH)) u_i_pipe (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_i_acc),
    .i_data  (w_i_rdata),
    .i_err   (w_i_err),
    .i_ready (i_resp_ready),
    .o_valid (i_resp_valid),
    .o_data  (i_resp_data),
    .o_err   (i_resp_err)
  );

  pipelined_memory_resp_pipe #(.LAT(READ_LATENCY), .DW(DATA_WIDTH)) u_d_pipe (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_d_acc),
    .i_data  (w_d_rdata),
    .i_err   (w_d_err),
    .i_ready (d_resp_ready),
    .o_valid (d_resp_valid),
    .o_data  (d_resp_data),
    .o_err   (d_resp_err)
  );
endmodule

// File: tb/tb_pipelined_memory.sv
// tb/tb_pipelined_memory.sv - directed self-checking bench for pipelined_memory
// Three instances: A (latency 1), B (latency 3), C (zero-fill, 64 bytes).

module tb_pipelined_memory;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;

  logic a_iv, a_ir, a_irv, a_irr, a_ire, a_dv, a_dr, a_dwe, a_drv, a_drr, a_dre, a_busy;
  logic [31:0] a_ia, a_ird, a_da, a_dwd, a_drd;
  logic [3:0]  a_dbe;
  logic b_iv, b_ir, b_irv, b_irr, b_ire, b_dv, b_dr, b_dwe, b_drv, b_drr, b_dre, b_busy;
  logic [31:0] b_ia, b_ird, b_da, b_dwd, b_drd;
  logic [3:0]  b_dbe;
  logic c_iv, c_ir, c_irv, c_irr, c_ire, c_dv, c_dr, c_dwe, c_drv, c_drr, c_dre, c_busy;
  logic [31:0] c_ia, c_ird, c_da, c_dwd, c_drd;
  logic [3:0]  c_dbe;

  pipelined_memory #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_SIZE(1024), .READ_LATENCY(1), .CLEAR_ON_RESET(0)) u_a (
    .clk(clk), .rst(rst),
    .i_req_valid(a_iv), .i_req_ready(a_ir), .i_req_addr(a_ia),
    .i_resp_valid(a_irv), .i_resp_ready(a_irr), .i_resp_data(a_ird), .i_resp_err(a_ire),
    .d_req_valid(a_dv), .d_req_ready(a_dr), .d_req_addr(a_da), .d_req_we(a_dwe),
    .d_req_wdata(a_dwd), .d_req_be(a_dbe),
    .d_resp_valid(a_drv), .d_resp_ready(a_drr), .d_resp_data(a_drd), .d_resp_err(a_dre),
    .busy(a_busy));

  pipelined_memory #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_SIZE(1024), .READ_LATENCY(3), .CLEAR_ON_RESET(0)) u_b (
    .clk(clk), .rst(rst),
    .i_req_valid(b_iv), .i_req_ready(b_ir), .i_req_addr(b_ia),
    .i_resp_valid(b_irv), .i_resp_ready(b_irr), .i_resp_data(b_ird), .i_resp_err(b_ire),
    .d_req_valid(b_dv), .d_req_ready(b_dr), .d_req_addr(b_da), .d_req_we(b_dwe),
    .d_req_wdata(b_dwd), .d_req_be(b_dbe),
    .d_resp_valid(b_drv), .d_resp_ready(b_drr), .d_resp_data(b_drd), .d_resp_err(b_dre),
    .busy(b_busy));

  pipelined_memory #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_SIZE(64), .READ_LATENCY(1), .CLEAR_ON_RESET(1)) u_c (
    .clk(clk), .rst(rst),
    .i_req_valid(c_iv), .i_req_ready(c_ir), .i_req_addr(c_ia),
    .i_resp_valid(c_irv), .i_resp_ready(c_irr), .i_resp_data(c_ird), .i_resp_err(c_ire),
    .d_req_valid(c_dv), .d_req_ready(c_dr), .d_req_addr(c_da), .d_req_we(c_dwe),
    .d_req_wdata(c_dwd), .d_req_be(c_dbe),
    .d_resp_valid(c_drv), .d_resp_ready(c_drr), .d_resp_data(c_drd), .d_resp_err(c_dre),
    .busy(c_busy));

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, act, exp);
    end
  endtask

  task automatic a_dop(input string tag, input logic [31:0] addr, input logic we,
                       input logic [31:0] wd, input logic [3:0] be,
                       input logic [31:0] exp_d, input logic exp_e);
    @(negedge clk);
    check({tag, "_rdy"}, a_dr, 1);
    a_dv = 1; a_da = addr; a_dwe = we; a_dwd = wd; a_dbe = be;
    @(negedge clk);
    a_dv = 0; a_dwe = 0;
    check({tag, "_v"}, a_drv, 1);
    check({tag, "_d"}, a_drd, exp_d);
    check({tag, "_e"}, a_dre, exp_e);
  endtask

  task automatic a_iop(input string tag, input logic [31:0] addr,
                       input logic [31:0] exp_d, input logic exp_e);
    @(negedge clk);
    check({tag, "_rdy"}, a_ir, 1);
    a_iv = 1; a_ia = addr;
    @(negedge clk);
    a_iv = 0;
    check({tag, "_v"}, a_irv, 1);
    check({tag, "_d"}, a_ird, exp_d);
    check({tag, "_e"}, a_ire, exp_e);
  endtask

  task automatic c_dop(input string tag, input logic [31:0] addr, input logic we,
                       input logic [31:0] wd, input logic [31:0] exp_d);
    @(negedge clk);
    check({tag, "_rdy"}, c_dr, 1);
    c_dv = 1; c_da = addr; c_dwe = we; c_dwd = wd; c_dbe = 4'hF;
    @(negedge clk);
    c_dv = 0; c_dwe = 0;
    check({tag, "_v"}, c_drv, 1);
    check({tag, "_d"}, c_drd, exp_d);
    check({tag, "_e"}, c_dre, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int seen;
    {a_iv, a_ia, a_dv, a_da, a_dwe, a_dwd, a_dbe} = '0;
    {b_iv, b_ia, b_dv, b_da, b_dwe, b_dwd, b_dbe} = '0;
    {c_iv, c_ia, c_dv, c_da, c_dwe, c_dwd, c_dbe} = '0;
    {a_irr, a_drr, b_irr, b_drr, c_irr, c_drr} = '1;

    repeat (2) @(negedge clk);
    check("rst_a_busy", a_busy, 0);
    check("rst_c_busy", c_busy, 1);
    check("rst_a_iready", a_ir, 0);
    check("rst_a_dready", a_dr, 0);
    check("rst_a_ivalid", a_irv, 0);
    check("rst_b_dvalid", b_drv, 0);
    check("rst_b_idata", b_ird, 0);

    rst = 0;
    #1;
    cnt = 0;
    for (int k = 0; k < 100 && c_busy; k++) begin
      cnt++;
      check("clr_c_iready", c_ir, 0);
      @(negedge clk);
      #1;
    end
    check("clr_busy_cycles", cnt, 16);
    check("clr_done_ready", c_dr, 1);
    c_dop("c_rd0", 32'h00, 0, 0, 32'h0);
    c_dop("c_rd3c", 32'h3C, 0, 0, 32'h0);
    c_dop("c_wr3c", 32'h3C, 1, 32'hDEADBEEF, 32'h0);
    c_dop("c_rb3c", 32'h3C, 0, 0, 32'hDEADBEEF);

    // partial byte-enable write
    a_dop("a_zero10", 32'h10, 1, 32'h0, 4'hF, 32'h0, 0);
    a_dop("a_be_wr", 32'h10, 1, 32'hAABBCCDD, 4'b0101, 32'h0, 0);
    a_iop("a_be_rd", 32'h10, 32'h00BB00DD, 0);

    // same-cycle i-read and d-write to one word
    a_dop("a_pre20", 32'h20, 1, 32'h11111111, 4'hF, 32'h0, 0);
    @(negedge clk);
    a_iv = 1; a_ia = 32'h20;
    a_dv = 1; a_da = 32'h20; a_dwe = 1; a_dwd = 32'h22222222; a_dbe = 4'hF;
    @(negedge clk);
    a_dv = 0; a_dwe = 0;
    check("a_raw_old", a_ird, 32'h11111111);
    check("a_raw_wresp", a_drv, 1);
    @(negedge clk);
    a_iv = 0;
    check("a_raw_new", a_ird, 32'h22222222);

    // error addresses
    a_dop("a_w0", 32'h0, 1, 32'h12345678, 4'hF, 32'h0, 0);
    a_dop("a_mis_wr", 32'h3, 1, 32'hFFFFFFFF, 4'hF, 32'h0, 1);
    a_dop("a_mis_rd", 32'h3, 0, 0, 4'h0, 32'h0, 1);
    a_dop("a_oob_rd", 32'd1024, 0, 0, 4'h0, 32'h0, 1);
    a_dop("a_oob_wr", 32'd1024, 1, 32'hFFFFFFFF, 4'hF, 32'h0, 1);
    a_dop("a_r0", 32'h0, 0, 0, 4'h0, 32'h12345678, 0);
    a_dop("a_last_wr", 32'd1020, 1, 32'h5A5A5A5A, 4'hF, 32'h0, 0);
    a_dop("a_last_rd", 32'd1020, 0, 0, 4'h0, 32'h5A5A5A5A, 0);
    a_iop("a_i_mis", 32'h2, 32'h0, 1);

    // zero byte-enable still responds, changes nothing
    a_dop("a_w30", 32'h30, 1, 32'hCAFEBABE, 4'hF, 32'h0, 0);
    a_dop("a_be0", 32'h30, 1, 32'hFFFFFFFF, 4'h0, 32'h0, 0);
    a_dop("a_r30", 32'h30, 0, 0, 4'h0, 32'hCAFEBABE, 0);

    // B: fill three words, latency-3 write response
    @(negedge clk);
    b_dv = 1; b_dwe = 1; b_dbe = 4'hF; b_da = 32'h0; b_dwd = 32'hA0A0A0A0;
    @(negedge clk);
    b_da = 32'h4; b_dwd = 32'hB1B1B1B1;
    @(negedge clk);
    b_da = 32'h8; b_dwd = 32'hC2C2C2C2;
    @(negedge clk);
    b_dv = 0; b_dwe = 0;
    check("b_wr_lat3", b_drv, 1);
    check("b_wr_data0", b_drd, 0);
    repeat (3) @(negedge clk);

    // B: back-to-back reads with a two-cycle stall
    @(negedge clk);
    check("b_n0_ready", b_ir, 1);
    b_iv = 1; b_ia = 32'h0;
    @(negedge clk);
    check("b_n1_novalid", b_irv, 0);
    b_ia = 32'h4;
    @(negedge clk);
    check("b_n2_novalid", b_irv, 0);
    b_ia = 32'h8;
    @(negedge clk);
    b_iv = 0;
    check("b_n3_valid", b_irv, 1);
    check("b_n3_data", b_ird, 32'hA0A0A0A0);
    @(negedge clk);
    check("b_n4_data", b_ird, 32'hB1B1B1B1);
    b_irr = 0;
    @(negedge clk);
    check("b_n5_valid", b_irv, 1);
    check("b_n5_data", b_ird, 32'hB1B1B1B1);
    check("b_n5_ready", b_ir, 0);
    @(negedge clk);
    check("b_n6_valid", b_irv, 1);
    check("b_n6_data", b_ird, 32'hB1B1B1B1);
    check("b_n6_ready", b_ir, 0);
    b_irr = 1;
    @(negedge clk);
    check("b_n7_valid", b_irv, 1);
    check("b_n7_data", b_ird, 32'hC2C2C2C2);
    @(negedge clk);
    check("b_n8_idle", b_irv, 0);

    // reset with two reads in flight
    @(negedge clk);
    b_iv = 1; b_ia = 32'h4;
    @(negedge clk);
    b_ia = 32'h8;
    @(negedge clk);
    b_iv = 0;
    rst = 1;
    #1;
    check("r2_b_ready", b_ir, 0);
    check("r2_b_busy", b_busy, 0);
    check("r2_c_busy", c_busy, 1);
    @(negedge clk);
    rst = 0;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (b_irv || b_drv) seen++;
      @(negedge clk);
    end
    check("r2_no_resp", seen, 0);
    b_iv = 1; b_ia = 32'h8;
    @(negedge clk);
    b_iv = 0;
    repeat (2) @(negedge clk);
    check("r2_post_valid", b_irv, 1);
    check("r2_post_data", b_ird, 32'hC2C2C2C2);
    a_iop("r2_a_keep", 32'h30, 32'hCAFEBABE, 0);
    repeat (12) @(negedge clk);
    c_dop("r2_c_cleared", 32'h3C, 0, 0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
